rca_slice_sequencer: RTL and testbench

//  Multi-cycle wide adder controller. Accepts one WIDTH-bit add (a + b + c_in) per

---
 rtl/rca_slice_sequencer_if.sv | 35 +++
 rtl/rca_slice_sequencer.sv | 145 ++++++++++++++
 tb/tb_rca_slice_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rca_slice_sequencer_if.sv
// Operand/result bundle for rca_slice_sequencer.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where the sender's valid and the receiver's ready are both high. A sender
// holds its payload stable while valid is high and not yet accepted.
//
// Signals:
//   in_valid / in_ready        operand channel (producer -> sequencer)
//   in_a, in_b, in_c           addends and carry-in
//   out_valid / out_ready      result channel (sequencer -> consumer)
//   out_sum, out_c_out         WIDTH-bit sum and carry-out of the top slice
// Modports: master = producer/consumer side, slave = sequencer side.
interface rca_slice_sequencer_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_c_out;

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_sum, out_c_out
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_sum, out_c_out
  );
endinterface

// File: rtl/rca_slice_sequencer.sv
// Multi-cycle wide adder: a WIDTH-bit a + b + c_in is evaluated through one
// SLICE-bit ripple-carry adder, one slice per cycle, LSB slice first. The
// slice carry-out is registered and feeds the next slice.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   bus        rca_slice_sequencer_if.slave (operand and result channels)
//   busy       high while an operation is in RUN or DONE
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)

module ripple_carry_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);
  logic [W:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[W];
endmodule

module rca_slice_sequencer #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  rca_slice_sequencer_if.slave  bus,
  output logic                  busy,
  output logic [1:0]            state_dbg
);
  localparam int NSLICES = WIDTH / SLICE;
  localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICES - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      shamt;
  logic [SLICE-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;

  // Bit offset of the slice being evaluated; shifts avoid a variable part-select.
  assign shamt   = 32'(cnt_q) * 32'(SLICE);
  assign slice_a = SLICE'(a_q >> shamt);
  assign slice_b = SLICE'(b_q >> shamt);

  ripple_carry_adder #(.W(SLICE)) u_rca (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_c;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Merge this slice's sum into its lane; other lanes keep their value.
        sum_d   = (sum_q & ~(SLICE_MASK << shamt)) | (WIDTH'(slice_sum) << shamt);
        carry_d = slice_cout;
        if (cnt_q == LAST_SLICE) begin
          cout_d  = slice_cout;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // Return to IDLE only; a new accept waits for the following cycle.
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_c_out = cout_q;
  assign busy          = (state_q != S_IDLE);
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_rca_slice_sequencer.sv
module tb_rca_slice_sequencer;
  localparam int WIDTH   = 64;
  localparam int SLICE   = 16;
  localparam int NSLICES = WIDTH / SLICE;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH:0] exp_q[$];

  rca_slice_sequencer_if #(.WIDTH(WIDTH)) bus_if ();

  rca_slice_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  // Presents operands until accepted; returns at the negedge after the accept edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    bit ok;
    ok = 1'b0;
    bus_if.in_a     = a;
    bus_if.in_b     = b;
    bus_if.in_c     = c;
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 20 cycles", bus_if.in_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_a      = '0;
    bus_if.in_b      = '0;
    bus_if.in_c      = 1'b0;
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus_if.in_ready, bus_if.out_valid, busy, state_dbg} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: {in_ready,out_valid,busy,state}=%b required 10000",
               {bus_if.in_ready, bus_if.out_valid, busy, state_dbg});
    end
    n_checks++;
    if ({bus_if.out_c_out, bus_if.out_sum} !== 65'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %h required 0", {bus_if.out_c_out, bus_if.out_sum});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [WIDTH-1:0] va[4];
    logic [WIDTH-1:0] vb[4];
    logic             vc[4];
    logic [WIDTH:0]   vexp[4];
    bit ok;
    // carry across every slice / carry across one slice boundary / all-ones + all-ones + 1
    va[0] = '1;                        vb[0] = '0;  vc[0] = 1'b1; vexp[0] = {1'b1, 64'h0};
    va[1] = 64'h0000_0000_0000_FFFF;   vb[1] = 64'd1; vc[1] = 1'b0; vexp[1] = {1'b0, 64'h0000_0000_0001_0000};
    va[2] = '1;                        vb[2] = '1;  vc[2] = 1'b1; vexp[2] = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    va[3] = 64'h8000_0000_0000_0000;   vb[3] = 64'h8000_0000_0000_0000; vc[3] = 1'b0;
    vexp[3] = {1'b1, 64'h0};
    for (int i = 0; i < 4; i++) begin
      bus_if.out_ready = 1'b0;
      send(va[i], vb[i], vc[i]);
      wait_out_valid(ok);
      n_checks++;
      if (!ok || {bus_if.out_c_out, bus_if.out_sum} !== vexp[i]) begin
        n_fail++;
        $display("FAIL vector_%0d: got %h required %h (valid=%b)", i,
                 {bus_if.out_c_out, bus_if.out_sum}, vexp[i], bus_if.out_valid);
      end
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      n_checks++;
      if ({bus_if.out_valid, bus_if.in_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL vector_%0d_release: {out_valid,in_ready}=%b required 01", i,
                 {bus_if.out_valid, bus_if.in_ready});
      end
    end
  endtask

  task automatic test_latency();
    bus_if.out_ready = 1'b1;
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    for (int k = 1; k <= NSLICES; k++) begin
      n_checks++;
      if ({bus_if.out_valid, bus_if.in_ready, busy} !== 3'b001) begin
        n_fail++;
        $display("FAIL latency_run_T+%0d: {out_valid,in_ready,busy}=%b required 001", k,
                 {bus_if.out_valid, bus_if.in_ready, busy});
      end
      @(negedge clk);
    end
    n_checks++;
    if ({bus_if.out_valid, bus_if.in_ready} !== 2'b10 ||
        {bus_if.out_c_out, bus_if.out_sum} !== {1'b0, 64'h2222_2222_2222_2212}) begin
      n_fail++;
      $display("FAIL latency_done: valid=%b in_ready=%b result=%h required 1,0,%h",
               bus_if.out_valid, bus_if.in_ready, {bus_if.out_c_out, bus_if.out_sum},
               {1'b0, 64'h2222_2222_2222_2212});
    end
    @(negedge clk);
    n_checks++;
    if ({bus_if.out_valid, bus_if.in_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL latency_after: {out_valid,in_ready,busy}=%b required 010",
               {bus_if.out_valid, bus_if.in_ready, busy});
    end
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    bus_if.out_ready = 1'b0;
    send(64'd5, 64'd7, 1'b0);
    wait_out_valid(ok);
    for (int k = 0; k < 6; k++) begin
      bus_if.in_a = 64'(k * 1000 + 17);  // ignored while busy
      n_checks++;
      if (!ok || bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0 ||
          {bus_if.out_c_out, bus_if.out_sum} !== 65'd12) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: valid=%b in_ready=%b result=%h required 1,0,%h",
                 k, bus_if.out_valid, bus_if.in_ready, {bus_if.out_c_out, bus_if.out_sum}, 65'd12);
      end
      @(negedge clk);
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    n_checks++;
    if ({bus_if.out_valid, bus_if.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL backpressure_release: {out_valid,in_ready}=%b required 01",
               {bus_if.out_valid, bus_if.in_ready});
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    // reset in the second RUN cycle
    bus_if.out_ready = 1'b0;
    send(64'h1111_1111_1111_1111, 64'd1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({bus_if.in_ready, bus_if.out_valid, busy, state_dbg} !== 5'b10000 ||
        {bus_if.out_c_out, bus_if.out_sum} !== 65'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: {in_ready,out_valid,busy,state}=%b result=%h required 10000,0",
               {bus_if.in_ready, bus_if.out_valid, busy, state_dbg}, {bus_if.out_c_out, bus_if.out_sum});
    end
    send(64'd3, 64'd4, 1'b1);
    wait_out_valid(ok);
    n_checks++;
    if (!ok || {bus_if.out_c_out, bus_if.out_sum} !== 65'd8) begin
      n_fail++;
      $display("FAIL after_reset_add: got %h required %h", {bus_if.out_c_out, bus_if.out_sum}, 65'd8);
    end
    // reset while holding a result in DONE with out_ready low
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({bus_if.in_ready, bus_if.out_valid, busy} !== 3'b100 ||
        {bus_if.out_c_out, bus_if.out_sum} !== 65'd0) begin
      n_fail++;
      $display("FAIL reset_in_done: {in_ready,out_valid,busy}=%b result=%h required 100,0",
               {bus_if.in_ready, bus_if.out_valid, busy}, {bus_if.out_c_out, bus_if.out_sum});
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    logic             c;
    bit               done;
    for (int n = 0; n < 100; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = 1'($urandom_range(0, 1));
      exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c});
      bus_if.out_ready = 1'b0;
      send(a, b, c);
      done = 1'b0;
      for (int i = 0; i < 60; i++) begin
        bus_if.in_a      = {$urandom, $urandom};
        bus_if.in_b      = {$urandom, $urandom};
        bus_if.in_c      = 1'($urandom_range(0, 1));
        bus_if.out_ready = 1'($urandom_range(0, 1));
        if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
          n_checks++;
          if (exp_q.size() == 0 || {bus_if.out_c_out, bus_if.out_sum} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL random_%0d: got %h required %h", n,
                     {bus_if.out_c_out, bus_if.out_sum}, (exp_q.size() != 0) ? exp_q[0] : 'x);
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          @(negedge clk);
          bus_if.out_ready = 1'b0;
          n_checks++;
          if (bus_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL random_%0d_once: out_valid=%b required 0", n, bus_if.out_valid);
          end
          done = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("FAIL random_%0d_timeout: out_valid=%b required 1 within 60 cycles", n, bus_if.out_valid);
      end
    end
    bus_if.out_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: %0d results outstanding required 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_vectors();
    test_latency();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
